window_3x3_gen: RTL and testbench
=================================

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1650, meaning total pixel clocks per video line including blanking; legal range 4..4095.
REQ-002 SHALL have parameter DW, default 24, meaning pixel width, packed {blue[23:16], green[15:8], red[7:0]}.
REQ-003 SHALL have port pclk, input, 1, pixel clock; the block uses only this clock.
REQ-004 SHALL have port rstin, input, 1, reset, synchronous to pclk and active-high.
REQ-005 SHALL have ports pix_in (input, DW, received pixel), hsync_in (input, 1), vsync_in (input, 1) and de_in (input, 1); all are sampled every pclk, with no stall.
REQ-006 SHALL have port window, output, 9*DW, the 3x3 neighbourhood.
REQ-007 SHALL have ports hsync_out, vsync_out and de_out, each output, 1, sync aligned to the window centre.
REQ-008 SHALL have port win_valid, output, 1, high once the delay lines are primed.
REQ-009 SHALL have port line_len_err, output, 1, one-cycle pulse on a line-length mismatch.

Function
REQ-010 SHALL store {de, pix} words in two line-delay RAMs, each H_TOTAL deep and DW+1 wide, read-before-write, sharing one address pointer.
REQ-011 SHALL advance the address pointer every pclk, including blanking, over 0..H_TOTAL-1, wrapping to 0.
REQ-012 SHALL feed the input to RAM1 and RAM1 output to RAM2, so each RAM is an exact H_TOTAL-cycle delay.
REQ-013 SHALL define W[k][j] (k = row 0..2, j = column 0..2) as the input {de, pix} delayed exactly k*H_TOTAL + 1 + j cycles; row 2 = top line, column 2 = leftmost pixel.
REQ-014 SHALL pack window[(3k+j)*DW +: DW] = W[k][j].de ? W[k][j].pix : 0, so that taps outside active video read as zero.
REQ-015 SHALL set the centre tap to W[1][1], with latency H_TOTAL+2 cycles from pix_in.
REQ-016 SHALL delay hsync, vsync and de by exactly H_TOTAL+2 cycles, stored alongside the pixel in the delay path, and drive them on hsync_out, vsync_out and de_out.
REQ-017 SHALL run a prime counter from 0 after reset and assert win_valid when it reaches 2*H_TOTAL+3, then hold win_valid high and stop the counter.
REQ-018 SHALL force window, hsync_out, vsync_out and de_out to 0 while win_valid is 0.
REQ-019 SHALL run a 12-bit line counter that restarts at 1 on each hsync_in rising edge and saturates at 4095.
REQ-020 SHALL, on each hsync_in rising edge other than the first after reset, pulse line_len_err for one cycle, one cycle after the edge, if the counter value is not equal to H_TOTAL.
REQ-021 SHALL treat simultaneous hsync and vsync edges identically to a lone hsync edge, with no special case.
REQ-022 SHALL NOT let line_len_err affect the data path; it is status only.

Reset
REQ-023 SHALL, while rstin is high at a pclk edge, clear the pointer, prime counter, line counter, first-edge flag, all tap registers and all outputs to 0 on the next edge.
REQ-024 SHALL leave RAM contents unreset; stale RAM data is masked by REQ-018 until priming completes.
REQ-025 SHALL apply reset asserted mid-frame within one cycle, then re-prime from scratch per REQ-017.

Verification
REQ-026 SHALL cover priming: with H_TOTAL=8, constant de_in=1 and pix_in=cycle index, win_valid rises exactly 19 cycles after rstin falls, and window, hsync_out, vsync_out and de_out are 0 before that.
REQ-027 SHALL cover window contents: with H_TOTAL=8, an incrementing pixel and all de=1, after priming centre = input-10, W[0][0] = input-1 and W[2][2] = input-19, matching cycle for cycle.
REQ-028 SHALL cover border masking: with H_TOTAL=8 and de_in high only on columns 1..6, centre at column 1 shows the W[*][2] taps as 0 and all other taps nonzero.
REQ-029 SHALL cover sync alignment: a single hsync_in pulse at cycle t after priming appears on hsync_out exactly at t+10 with identical width.
REQ-030 SHALL cover line-length check: hsync_in edges 8 apart give no line_len_err; one line of 9 gives exactly one single-cycle pulse; the first edge after reset never pulses.
REQ-031 SHALL cover reset mid-operation: asserting rstin for 1 cycle mid-frame clears win_valid and all outputs next cycle, and win_valid returns 19 cycles after release.

Source files
------------

// File: rtl/window_3x3_gen.sv
// 3x3 pixel neighbourhood generator: two line-delay RAMs plus a 3-tap shift row
// per line give a sliding window, with sync re-aligned to the window centre.
module window_3x3_gen #(
    parameter int H_TOTAL = 1650,
    parameter int DW      = 24
) (
    input  logic              pclk,
    input  logic              rstin,
    input  logic [DW-1:0]     pix_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    output logic [9*DW-1:0]   window,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic              win_valid,
    output logic              line_len_err
);

    localparam int              PTR_W     = $clog2(H_TOTAL);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(H_TOTAL - 1);
    localparam logic [13:0]     PRIME_LEN = 14'(2 * H_TOTAL + 3);
    localparam logic [11:0]     LINE_LEN  = 12'(H_TOTAL);
    localparam logic [11:0]     LINE_MAX  = 12'hFFF;

    // Line-delay storage; contents are never reset, stale words stay masked
    // until priming has flushed both lines.
    logic [DW:0]      ram1     [H_TOTAL];
    logic [DW:0]      ram2     [H_TOTAL];
    logic [1:0]       sync_ram [H_TOTAL];

    logic [PTR_W-1:0] ptr;
    logic [DW:0]      ram1_rd;
    logic [DW:0]      ram2_rd;
    logic [1:0]       sync_rd;

    logic [DW:0]      tap [3][3];
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;

    logic [13:0]      prime_cnt;
    logic             hs_d;
    logic             hs_rise;
    logic [11:0]      line_cnt;
    logic             first_seen;

    function automatic logic [DW-1:0] mask_tap(input logic [DW:0] t);
        return t[DW] ? t[DW-1:0] : '0;
    endfunction

    // Read-before-write: the word read this cycle was written H_TOTAL edges ago.
    assign ram1_rd = ram1[ptr];
    assign ram2_rd = ram2[ptr];
    assign sync_rd = sync_ram[ptr];

    always_ff @(posedge pclk) begin
        ram1[ptr]     <= {de_in, pix_in};
        ram2[ptr]     <= ram1_rd;
        sync_ram[ptr] <= {vsync_in, hsync_in};
    end

    always_ff @(posedge pclk) begin
        if (rstin) begin
            ptr <= '0;
        end else if (ptr == PTR_LAST) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + 1'b1;
        end
    end

    // Stage p0: column 0 of each row; later columns shift one pixel left.
    always_ff @(posedge pclk) begin
        if (rstin) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    tap[k][j] <= '0;
                end
            end
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            tap[0][0] <= {de_in, pix_in};
            tap[1][0] <= ram1_rd;
            tap[2][0] <= ram2_rd;
            for (int k = 0; k < 3; k++) begin
                tap[k][1] <= tap[k][0];
                tap[k][2] <= tap[k][1];
            end
            sync_p0 <= sync_rd;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rstin) begin
            prime_cnt <= '0;
            win_valid <= 1'b0;
        end else if (!win_valid) begin
            prime_cnt <= prime_cnt + 14'd1;
            if (prime_cnt + 14'd1 == PRIME_LEN) begin
                win_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        window = '0;
        if (win_valid) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    window[(3*k+j)*DW +: DW] = mask_tap(tap[k][j]);
                end
            end
        end
    end

    assign hsync_out = win_valid & sync_p1[0];
    assign vsync_out = win_valid & sync_p1[1];
    assign de_out    = win_valid & tap[1][1][DW];

    // Line-length monitor: status only, never touches the pixel path.
    assign hs_rise = hsync_in & ~hs_d;

    always_ff @(posedge pclk) begin
        if (rstin) begin
            hs_d         <= 1'b0;
            line_cnt     <= '0;
            first_seen   <= 1'b0;
            line_len_err <= 1'b0;
        end else begin
            hs_d         <= hsync_in;
            line_len_err <= 1'b0;
            if (hs_rise) begin
                line_cnt   <= 12'd1;
                first_seen <= 1'b1;
                if (first_seen && (line_cnt != LINE_LEN)) begin
                    line_len_err <= 1'b1;
                end
            end else if (line_cnt != LINE_MAX) begin
                line_cnt <= line_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen with H_TOTAL=8: priming, window taps,
// border masking, sync alignment, line-length pulses and mid-frame reset.
module tb_window_3x3_gen;

    localparam int H  = 8;
    localparam int DW = 24;

    logic              pclk = 1'b0;
    logic              rstin;
    logic [DW-1:0]     pix_in;
    logic              hsync_in;
    logic              vsync_in;
    logic              de_in;
    logic [9*DW-1:0]   window;
    logic              hsync_out;
    logic              vsync_out;
    logic              de_out;
    logic              win_valid;
    logic              line_len_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    window_3x3_gen #(.H_TOTAL(H), .DW(DW)) dut (
        .pclk         (pclk),
        .rstin        (rstin),
        .pix_in       (pix_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .de_in        (de_in),
        .window       (window),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .de_out       (de_out),
        .win_valid    (win_valid),
        .line_len_err (line_len_err)
    );

    always #5 pclk = ~pclk;

    // Stimulus plan, indexed by the cycle in which the value is driven.
    function automatic logic de_at(input int d);
        if (d < 0) return 1'b0;
        if (d < 80) return 1'b1;
        return ((d % 8) >= 1) && ((d % 8) <= 6);
    endfunction

    function automatic logic hs_at(input int d);
        return (d == 30) || (d == 31) || (d == 32) || (d == 38) || (d == 46) ||
               (d == 55) || (d == 63) || (d == 140) || (d == 148);
    endfunction

    function automatic logic vs_at(input int d);
        return (d == 34) || (d == 55) || (d == 56);
    endfunction

    // Valid after 19 edges from reset release; reset pulse driven in cycle 130.
    function automatic logic valid_exp(input int c);
        return ((c >= 19) && (c <= 130)) || (c >= 150);
    endfunction

    function automatic logic [9*DW-1:0] win_exp(input int c);
        logic [9*DW-1:0] w;
        w = '0;
        if (valid_exp(c)) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    int d;
                    d = c - (8 * k + 1 + j);
                    w[(3*k+j)*DW +: DW] = de_at(d) ? DW'(d) : '0;
                end
            end
        end
        return w;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int v0, input int v1, input int v2,
                                              input int v3, input int v4, input int v5,
                                              input int v6, input int v7, input int v8);
        return {DW'(v8), DW'(v7), DW'(v6), DW'(v5), DW'(v4),
                DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %b, expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [9*DW-1:0] obs,
                           input logic [9*DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rstin    = 1'b1;
        pix_in   = '0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in    = 1'b0;
        repeat (4) @(posedge pclk);

        for (int c = 0; c < 176; c++) begin
            @(posedge pclk);
            #1;
            cyc = c;

            if (c == 0) begin
                chk_bit("reset_valid", win_valid, 1'b0);
                chk_win("reset_window", window, '0);
                chk_bit("reset_err", line_len_err, 1'b0);
            end

            chk_bit("win_valid", win_valid, valid_exp(c));
            chk_win("window", window, win_exp(c));
            chk_bit("hsync_out", hsync_out, valid_exp(c) && hs_at(c - 10));
            chk_bit("vsync_out", vsync_out, valid_exp(c) && vs_at(c - 10));
            chk_bit("de_out", de_out, valid_exp(c) && de_at(c - 10));
            chk_bit("line_len_err", line_len_err, c == 56);

            if (c == 18) chk_bit("prime_edge_low", win_valid, 1'b0);
            if (c == 25) chk_win("taps_c25", window, pack9(24, 23, 22, 16, 15, 14, 8, 7, 6));
            if (c == 107) chk_win("border_col1", window, pack9(106, 105, 0, 98, 97, 0, 90, 89, 0));
            if (c == 131) begin
                chk_bit("midrst_valid", win_valid, 1'b0);
                chk_win("midrst_window", window, '0);
                chk_bit("midrst_de", de_out, 1'b0);
            end
            if (c == 149) chk_bit("reprime_low", win_valid, 1'b0);
            if (c == 150) chk_bit("reprime_high", win_valid, 1'b1);

            rstin    = (c == 130);
            pix_in   = DW'(c);
            de_in    = de_at(c);
            hsync_in = hs_at(c);
            vsync_in = vs_at(c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
